// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, a 2-entry in-order
// response buffer, and the IF/ID register with redirect and stall handling.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   logic [31:0] fetch_pc_p0;
   logic [1:0]  outstanding;
   logic [1:0]  drop_cnt;

   logic [1:0]  fb_cnt;
   logic        fb_rd_ptr;
   logic        fb_wr_ptr;
   logic [31:0] fb_pc   [2];
   logic [31:0] fb_inst [2];

   logic        vld_p1;
   logic [31:0] pc_p1;
   logic [31:0] inst_p1;

   logic        credit_ok;
   logic        issue;
   logic        rsp;
   logic        rsp_keep;
   logic [31:0] rsp_pc;
   logic        pop;
   logic        bypass;
   logic        push;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   always_comb begin
      credit_ok = ({1'b0, outstanding} + {1'b0, fb_cnt}) < 3'd2;
      imem_req  = rst_n & ~redirect & credit_ok;
      issue     = imem_req & imem_ready;
      rsp       = imem_rvalid & (outstanding != 2'd0);
      rsp_keep  = rsp & ~redirect & (drop_cnt == 2'd0);
      // Live responses are contiguous behind fetch_pc once the stale ones drain.
      rsp_pc    = fetch_pc_p0 - {28'd0, outstanding, 2'b00};
      pop       = ~redirect & ~stall & (fb_cnt != 2'd0);
      bypass    = ~redirect & ~stall & (fb_cnt == 2'd0) & rsp_keep;
      push      = rsp_keep & ~bypass;
   end

   assign imem_addr = fetch_pc_p0;

   // Stage 0: fetch PC and in-flight bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_p0 <= word_align(RESET_PC);
         outstanding <= 2'd0;
         drop_cnt    <= 2'd0;
      end else begin
         if (redirect) begin
            fetch_pc_p0 <= word_align(redirect_pc);
         end else if (issue) begin
            fetch_pc_p0 <= pc_plus4(fetch_pc_p0);
         end
         outstanding <= outstanding + {1'b0, issue} - {1'b0, rsp};
         if (redirect) begin
            drop_cnt <= outstanding - {1'b0, rsp};
         end else if (rsp && (drop_cnt != 2'd0)) begin
            drop_cnt <= drop_cnt - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_cnt    <= 2'd0;
         fb_rd_ptr <= 1'b0;
         fb_wr_ptr <= 1'b0;
      end else if (redirect) begin
         fb_cnt    <= 2'd0;
         fb_rd_ptr <= 1'b0;
         fb_wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            fb_wr_ptr <= ~fb_wr_ptr;
         end
         if (pop) begin
            fb_rd_ptr <= ~fb_rd_ptr;
         end
         fb_cnt <= fb_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fb_pc[fb_wr_ptr]   <= rsp_pc;
         fb_inst[fb_wr_ptr] <= imem_rdata;
      end
   end

   // Stage 1: IF/ID register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         pc_p1   <= 32'd0;
         inst_p1 <= NOP_INST;
      end else if (redirect) begin
         vld_p1  <= 1'b0;
         inst_p1 <= NOP_INST;
      end else if (!stall) begin
         if (pop) begin
            vld_p1  <= 1'b1;
            pc_p1   <= fb_pc[fb_rd_ptr];
            inst_p1 <= fb_inst[fb_rd_ptr];
         end else if (bypass) begin
            vld_p1  <= 1'b1;
            pc_p1   <= rsp_pc;
            inst_p1 <= imem_rdata;
         end else begin
            vld_p1  <= 1'b0;
            inst_p1 <= NOP_INST;
         end
      end
   end

   assign if_valid = vld_p1;
   assign if_pc    = pc_p1;
   assign if_inst  = inst_p1;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and randomized bench for inst_fetch_unit against a queue-based
// reference model with an in-order memory that returns the address as data.
module tb_inst_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   always #5 clk = ~clk;

   inst_fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
   );

   typedef struct packed {logic [31:0] pc; logic stale;} infl_t;
   typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
   typedef struct packed {logic [31:0] addr; logic [31:0] rt;} mreq_t;

   infl_t       m_infl[$];
   ent_t        m_buf[$];
   mreq_t       mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_ifpc;
   logic [31:0] m_ifinst;
   logic        m_ifv;
   logic [31:0] cyc = 32'd0;
   int          lat = 1;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_infl.delete();
      m_buf.delete();
      mq.delete();
      m_pc     = RST_PC;
      m_ifv    = 1'b0;
      m_ifpc   = 32'd0;
      m_ifinst = NOP;
   endtask

   // One clock: drive at negedge, check combinational outputs, step model at posedge.
   task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
      logic        exp_req, issued, rv, keep;
      logic [31:0] addr_s;
      infl_t       r;
      ent_t        e;
      @(negedge clk);
      stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
      if (mq.size() > 0 && mq[0].rt <= cyc) begin
         imem_rvalid = 1'b1; imem_rdata = mq[0].addr;
      end else begin
         imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      exp_req = !rd && ((m_infl.size() + m_buf.size()) < 2);
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      chk("imem_addr", imem_addr, m_pc);
      issued = imem_req && imem_ready;
      addr_s = imem_addr;
      rv     = imem_rvalid;
      @(posedge clk);
      if (rv) void'(mq.pop_front());
      if (issued) mq.push_back('{addr_s, cyc + 32'(lat)});
      keep = 1'b0;
      r    = '0;
      if (rv && m_infl.size() > 0) begin
         r    = m_infl.pop_front();
         keep = !r.stale && !rd;
      end
      if (rd) begin
         foreach (m_infl[i]) m_infl[i].stale = 1'b1;
         m_buf.delete();
         m_ifv    = 1'b0;
         m_ifinst = NOP;
         m_pc     = rpc & 32'hFFFF_FFFC;
      end else begin
         if (keep) m_buf.push_back('{r.pc, r.pc});
         if (!st) begin
            if (m_buf.size() > 0) begin
               e = m_buf.pop_front();
               m_ifv = 1'b1; m_ifpc = e.pc; m_ifinst = e.inst;
            end else begin
               m_ifv = 1'b0; m_ifinst = NOP;
            end
         end
         if (exp_req && rdy) begin
            m_infl.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
      #1;
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_ifv});
      chk("if_pc", if_pc, m_ifpc);
      chk("if_inst", if_inst, m_ifinst);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; stall = 1'b0; imem_ready = 1'b0;
      #1;
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_inst", if_inst, NOP);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_imem_addr", imem_addr, RST_PC);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic        found;
      logic        st, rd, rdy;
      logic [31:0] rpc;

      model_reset();
      do_reset();
      chk("restart_addr", imem_addr, RST_PC);

      // Sustained stream from a 1-cycle memory
      lat = 1;
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      chk("seq0_pc", if_pc, 32'h0);
      chk("seq0_inst", if_inst, 32'h0);
      cycle(0, 0, 0, 1);
      chk("seq1_pc", if_pc, 32'h4);
      cycle(0, 0, 0, 1);
      chk("seq2_pc", if_pc, 32'h8);
      chk("seq2_valid", {31'd0, if_valid}, 32'd1);
      repeat (3) cycle(0, 0, 0, 1);

      // Stall mid-stream, then resume
      repeat (3) cycle(1, 0, 0, 1);
      repeat (4) cycle(0, 0, 0, 1);

      // Memory not ready
      repeat (5) cycle(0, 0, 0, 0);

      // Redirect with two requests in flight
      lat = 3;
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 1, 32'h0000_0102, 1);
      chk("redir_if_valid", {31'd0, if_valid}, 32'd0);
      chk("redir_addr", imem_addr, 32'h0000_0100);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(0, 0, 0, 1);
         if (if_valid) found = 1'b1;
      end
      chk("redir_valid_seen", {31'd0, found}, 32'd1);
      chk("redir_first_pc", if_pc, 32'h0000_0100);

      // Redirect coinciding with a response
      lat = 1;
      repeat (6) cycle(0, 0, 0, 1);
      cycle(0, 1, 32'h0000_0200, 1);
      chk("redir2_addr", imem_addr, 32'h0000_0200);
      chk("redir2_if_valid", {31'd0, if_valid}, 32'd0);
      repeat (4) cycle(0, 0, 0, 1);

      // Fetch PC wrap
      cycle(0, 1, 32'hFFFF_FFFC, 1);
      cycle(0, 0, 0, 1);
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      repeat (3) cycle(0, 0, 0, 1);

      // Asynchronous reset mid-burst
      do_reset();
      chk("restart2_addr", imem_addr, RST_PC);
      repeat (4) cycle(0, 0, 0, 1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         lat = $urandom_range(1, 3);
         st  = ($urandom % 10) < 3;
         rd  = ($urandom % 12) == 0;
         rdy = ($urandom % 10) < 7;
         rpc = $urandom;
         if (($urandom % 4) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         cycle(st, rd, rpc, rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
